// File: rtl/dual_issue_splitter_pkg.sv
// Shared definitions for the dual-issue splitter: FSM state encoding,
// default widths and the per-lane load command used by the issue register.
package dual_issue_splitter_pkg;

  // Default per-instruction payload width ({pc, inst, decoded control}).
  localparam int unsigned DATA_W_DEF = 64;

  // Default width of the saturating split-event counter.
  localparam int unsigned CNT_W_DEF = 16;

  // PASS: bundles flow straight through. SECOND: the younger half of a
  // split bundle is parked and waits for lane 0 to free up.
  typedef enum logic {
    ST_PASS   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  // Per-lane command to the issue register: when load is set the lane
  // valid takes the value of valid, and a valid load also captures the
  // payload. A load with valid=0 is a bubble and keeps the old payload.
  typedef struct packed {
    logic load;
    logic valid;
  } lane_ctl_t;

  // Build a lane command.
  function automatic lane_ctl_t lane_ctl(input logic load, input logic valid);
    lane_ctl_t c;
    c.load  = load;
    c.valid = valid;
    return c;
  endfunction

  // Idle command: leave the lane untouched.
  localparam lane_ctl_t LANE_HOLD = '{load: 1'b0, valid: 1'b0};

endpackage : dual_issue_splitter_pkg

// File: rtl/dual_issue_splitter_issue_reg.sv
// Two-lane issue register feeding EX. Each lane is loaded independently;
// a global clear drops both valids and takes priority over any load.
// Payloads only change on a valid load, so an emptied lane keeps showing
// the last instruction it held.
module dual_issue_splitter_issue_reg
  import dual_issue_splitter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clear,
  input  lane_ctl_t         i_ctl_0,
  input  lane_ctl_t         i_ctl_1,
  input  logic [DATA_W-1:0] i_data_0,
  input  logic [DATA_W-1:0] i_data_1,
  output logic              o_valid_0,
  output logic              o_valid_1,
  output logic [DATA_W-1:0] o_data_0,
  output logic [DATA_W-1:0] o_data_1
);

  lane_ctl_t         w_ctl [2];
  logic [DATA_W-1:0] w_din [2];

  logic [1:0]        r_valid;
  logic [DATA_W-1:0] r_data [2];

  assign w_ctl[0] = i_ctl_0;
  assign w_ctl[1] = i_ctl_1;
  assign w_din[0] = i_data_0;
  assign w_din[1] = i_data_1;

  // Lane valid/payload registers: reset, global clear, then per-lane load.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (reset) begin
      r_valid   <= '0;
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i_clear) begin
          r_valid[i] <= 1'b0;
        end else if (w_ctl[i].load) begin
          r_valid[i] <= w_ctl[i].valid;
          if (w_ctl[i].valid) begin
            r_data[i] <= w_din[i];
          end
        end
      end
    end
  end

  assign o_valid_0 = r_valid[0];
  assign o_valid_1 = r_valid[1];
  assign o_data_0  = r_data[0];
  assign o_data_1  = r_data[1];

endmodule : dual_issue_splitter_issue_reg

// File: rtl/dual_issue_splitter.sv
// Dual-issue splitter between decode and EX. Independent pairs issue
// together; a pair whose younger slot reads the older slot's rd is split:
// the older instruction issues alone on lane 0 and the younger one is
// parked, then issued on lane 0 once the issue register frees up.
// A flush kills everything held; a saturating counter tracks split events.
module dual_issue_splitter
  import dual_issue_splitter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  input  logic              io_in_valid1,
  input  logic [DATA_W-1:0] io_in_data_0,
  input  logic [DATA_W-1:0] io_in_data_1,
  input  logic              io_stallex,
  output logic              io_in_ready,
  input  logic              io_flush,
  output logic              io_out_valid_0,
  output logic              io_out_valid_1,
  output logic [DATA_W-1:0] io_out_data_0,
  output logic [DATA_W-1:0] io_out_data_1,
  input  logic              io_out_ready,
  output logic [CNT_W-1:0]  io_split_cnt
);

  // FSM and parked-instruction state.
  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_pend_data;
  logic [CNT_W-1:0]  r_split_cnt;

  // Issue-register handshake and commands.
  logic              w_busy;
  logic              w_free;
  logic              w_accept;
  logic              w_split;
  logic              w_pend_load;
  logic              w_clear;
  lane_ctl_t         w_ctl_0;
  lane_ctl_t         w_ctl_1;
  logic [DATA_W-1:0] w_ld_data_0;

  // The issue register can take new contents when it is empty or EX is
  // draining it this cycle.
  assign w_busy = io_out_valid_0 | io_out_valid_1;
  assign w_free = ~w_busy | io_out_ready;

  // A new bundle is only taken in PASS; while a younger instruction is
  // parked the front end must wait so program order is preserved.
  assign io_in_ready = ~reset & ~io_flush & (r_state == ST_PASS) & w_free;
  assign w_accept    = io_in_ready & io_in_valid;

  // The hazard flag only matters when the younger slot actually exists.
  assign w_split     = w_accept & io_in_valid1 & io_stallex;

  // Next-state and issue-register commands; flush overrides everything.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_ctl_0     = LANE_HOLD;
    w_ctl_1     = LANE_HOLD;
    w_ld_data_0 = io_in_data_0;
    w_pend_load = 1'b0;

    if (io_flush) begin
      w_clear     = 1'b1;
      w_state_nxt = ST_PASS;
    end else begin
      unique case (r_state)
        ST_PASS: begin
          if (w_accept) begin
            w_ctl_0 = lane_ctl(1'b1, 1'b1);
            if (w_split) begin
              // Older instruction goes alone; younger one is parked.
              w_ctl_1     = lane_ctl(1'b1, 1'b0);
              w_pend_load = 1'b1;
              w_state_nxt = ST_SECOND;
            end else begin
              w_ctl_1 = lane_ctl(1'b1, io_in_valid1);
            end
          end else if (io_out_ready) begin
            // EX drained the register and nothing replaces it.
            w_clear = 1'b1;
          end
        end

        ST_SECOND: begin
          // The parked instruction issues only after its producer has
          // left the issue register (or in the same cycle EX takes it).
          if (w_free) begin
            w_ld_data_0 = r_pend_data;
            w_ctl_0     = lane_ctl(1'b1, 1'b1);
            w_ctl_1     = lane_ctl(1'b1, 1'b0);
            w_state_nxt = ST_PASS;
          end
        end

        default: begin
          w_state_nxt = ST_PASS;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_PASS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Parked younger instruction of a split bundle; dropped implicitly when
  // a flush returns the FSM to PASS.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_data <= '0;
    end else if (w_pend_load) begin
      r_pend_data <= io_in_data_1;
    end
  end

  // Saturating split-event counter; survives flushes, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_split_cnt <= '0;
    end else if (w_split && (r_split_cnt != {CNT_W{1'b1}})) begin
      r_split_cnt <= r_split_cnt + CNT_W'(1);
    end
  end

  assign io_split_cnt = r_split_cnt;

  dual_issue_splitter_issue_reg #(
    .DATA_W (DATA_W)
  ) u_issue_reg (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_clear),
    .i_ctl_0   (w_ctl_0),
    .i_ctl_1   (w_ctl_1),
    .i_data_0  (w_ld_data_0),
    .i_data_1  (io_in_data_1),
    .o_valid_0 (io_out_valid_0),
    .o_valid_1 (io_out_valid_1),
    .o_data_0  (io_out_data_0),
    .o_data_1  (io_out_data_1)
  );

  // Lane 1 never carries an instruction without an older one on lane 0.
  a_lane1_needs_lane0: assert property (
    @(posedge clock) disable iff (reset) io_out_valid_1 |-> io_out_valid_0
  );

  // While a younger instruction is parked, lane 1 stays empty.
  a_second_lane1_empty: assert property (
    @(posedge clock) disable iff (reset) (r_state == ST_SECOND) |-> !io_out_valid_1
  );

endmodule : dual_issue_splitter

// File: tb/tb_dual_issue_splitter.sv
// Self-checking bench for dual_issue_splitter: a directed vector table,
// hand-written corner sequences (saturation, flush during reload, reset)
// and a randomized phase checked against a queue-based reference model.
// A second instance with a 2-bit counter shares the stimulus.
module tb_dual_issue_splitter;

  localparam int DW = 64;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_valid1;
  logic [DW-1:0] in_d0;
  logic [DW-1:0] in_d1;
  logic          stallex;
  logic          flush;
  logic          out_ready;

  logic          in_ready;
  logic          v0;
  logic          v1;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic [15:0]   cnt;

  logic          s_in_ready;
  logic          s_v0;
  logic          s_v1;
  logic [DW-1:0] s_d0;
  logic [DW-1:0] s_d1;
  logic [1:0]    s_cnt;

  int n_checks = 0;
  int n_errors = 0;

  dual_issue_splitter dut (
    .clock          (clock),
    .reset          (reset),
    .io_in_valid    (in_valid),
    .io_in_valid1   (in_valid1),
    .io_in_data_0   (in_d0),
    .io_in_data_1   (in_d1),
    .io_stallex     (stallex),
    .io_in_ready    (in_ready),
    .io_flush       (flush),
    .io_out_valid_0 (v0),
    .io_out_valid_1 (v1),
    .io_out_data_0  (d0),
    .io_out_data_1  (d1),
    .io_out_ready   (out_ready),
    .io_split_cnt   (cnt)
  );

  dual_issue_splitter #(.DATA_W(DW), .CNT_W(2)) dut_sat (
    .clock          (clock),
    .reset          (reset),
    .io_in_valid    (in_valid),
    .io_in_valid1   (in_valid1),
    .io_in_data_0   (in_d0),
    .io_in_data_1   (in_d1),
    .io_stallex     (stallex),
    .io_in_ready    (s_in_ready),
    .io_flush       (flush),
    .io_out_valid_0 (s_v0),
    .io_out_valid_1 (s_v1),
    .io_out_data_0  (s_d0),
    .io_out_data_1  (s_d1),
    .io_out_ready   (out_ready),
    .io_split_cnt   (s_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string         name;
    logic          rst, fl, vin, vi1, st;
    logic [DW-1:0] di0, di1;
    logic          ordy;
    logic          e_rdy, e_v0, e_v1;
    logic [DW-1:0] e_d0, e_d1;
    logic          chk_d;
    int            e_cnt;
    int            e_sat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name,
                              input logic rst, input logic fl, input logic vin,
                              input logic vi1, input logic st,
                              input logic [DW-1:0] di0, input logic [DW-1:0] di1,
                              input logic ordy, input logic e_rdy,
                              input logic e_v0, input logic e_v1,
                              input logic [DW-1:0] e_d0, input logic [DW-1:0] e_d1,
                              input logic chk_d, input int e_cnt, input int e_sat);
    vec_t v;
    v.name = name; v.rst = rst; v.fl = fl; v.vin = vin; v.vi1 = vi1; v.st = st;
    v.di0 = di0; v.di1 = di1; v.ordy = ordy; v.e_rdy = e_rdy; v.e_v0 = e_v0;
    v.e_v1 = e_v1; v.e_d0 = e_d0; v.e_d1 = e_d1; v.chk_d = chk_d;
    v.e_cnt = e_cnt; v.e_sat = e_sat;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle's inputs just after the falling edge.
  task automatic drive(input logic rst, input logic fl, input logic vin,
                       input logic vi1, input logic st,
                       input logic [DW-1:0] di0, input logic [DW-1:0] di1,
                       input logic ordy);
    @(negedge clock);
    reset     = rst;
    flush     = fl;
    in_valid  = vin;
    in_valid1 = vi1;
    stallex   = st;
    in_d0     = di0;
    in_d1     = di1;
    out_ready = ordy;
  endtask

  // Let the active edge happen and settle.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Reference model: transaction-level view of what EX should see.
  logic          m_v0, m_v1;
  logic [DW-1:0] m_d0, m_d1;
  logic [DW-1:0] m_wait[$];
  int            m_splits;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
    stallex = 1'b0; in_d0 = '0; in_d1 = '0; out_ready = 1'b0;

    //                name          rst fl vin v1 st  d0     d1     ordy  rdy v0 v1 ed0    ed1   chkd cnt sat
    vecs.push_back(mk("reset",       1, 0, 0, 0, 0, 64'h0,  64'h0,  0,   0, 0, 0, 64'h0,  64'h0,  1, 0, 0));
    vecs.push_back(mk("indep",       0, 0, 1, 1, 0, 64'h11, 64'h22, 1,   1, 1, 1, 64'h11, 64'h22, 0, 0, 0));
    vecs.push_back(mk("dep_c1",      0, 0, 1, 1, 1, 64'h11, 64'h22, 1,   1, 1, 0, 64'h11, 64'h0,  0, 1, 1));
    vecs.push_back(mk("dep_c2",      0, 0, 1, 1, 0, 64'h33, 64'h44, 1,   0, 1, 0, 64'h22, 64'h0,  0, 1, 1));
    vecs.push_back(mk("dep_c3",      0, 0, 1, 1, 0, 64'h33, 64'h44, 1,   1, 1, 1, 64'h33, 64'h44, 0, 1, 1));
    vecs.push_back(mk("drain",       0, 0, 0, 0, 0, 64'h0,  64'h0,  1,   1, 0, 0, 64'h0,  64'h0,  0, 1, 1));
    vecs.push_back(mk("bp_split",    0, 0, 1, 1, 1, 64'h55, 64'h66, 1,   1, 1, 0, 64'h55, 64'h0,  0, 2, 2));
    vecs.push_back(mk("bp_hold1",    0, 0, 1, 1, 0, 64'h77, 64'h88, 0,   0, 1, 0, 64'h55, 64'h0,  0, 2, 2));
    vecs.push_back(mk("bp_hold2",    0, 0, 1, 1, 0, 64'h77, 64'h88, 0,   0, 1, 0, 64'h55, 64'h0,  0, 2, 2));
    vecs.push_back(mk("bp_hold3",    0, 0, 1, 1, 0, 64'h77, 64'h88, 0,   0, 1, 0, 64'h55, 64'h0,  0, 2, 2));
    vecs.push_back(mk("bp_reload",   0, 0, 1, 1, 0, 64'h77, 64'h88, 1,   0, 1, 0, 64'h66, 64'h0,  0, 2, 2));
    vecs.push_back(mk("bp_hold_2nd", 0, 0, 1, 1, 0, 64'h77, 64'h88, 0,   0, 1, 0, 64'h66, 64'h0,  0, 2, 2));
    vecs.push_back(mk("bp_next",     0, 0, 1, 1, 0, 64'h77, 64'h88, 1,   1, 1, 1, 64'h77, 64'h88, 0, 2, 2));
    vecs.push_back(mk("drain2",      0, 0, 0, 0, 0, 64'h0,  64'h0,  1,   1, 0, 0, 64'h0,  64'h0,  0, 2, 2));
    vecs.push_back(mk("fl_split",    0, 0, 1, 1, 1, 64'h99, 64'hAA, 1,   1, 1, 0, 64'h99, 64'h0,  0, 3, 3));
    vecs.push_back(mk("fl_second",   0, 1, 1, 1, 0, 64'hBB, 64'hCC, 1,   0, 0, 0, 64'h0,  64'h0,  0, 3, 3));
    vecs.push_back(mk("fl_after",    0, 0, 0, 0, 0, 64'h0,  64'h0,  0,   1, 0, 0, 64'h0,  64'h0,  0, 3, 3));
    vecs.push_back(mk("single",      0, 0, 1, 0, 1, 64'hDD, 64'hEE, 0,   1, 1, 0, 64'hDD, 64'h0,  0, 3, 3));
    vecs.push_back(mk("single_hold", 0, 0, 1, 1, 0, 64'h12, 64'h13, 0,   0, 1, 0, 64'hDD, 64'h0,  0, 3, 3));
    vecs.push_back(mk("fl_pass",     0, 1, 1, 1, 0, 64'h12, 64'h13, 0,   0, 0, 0, 64'h0,  64'h0,  0, 3, 3));
    vecs.push_back(mk("rst_split",   0, 0, 1, 1, 1, 64'h12, 64'h34, 1,   1, 1, 0, 64'h12, 64'h0,  0, 4, 3));
    vecs.push_back(mk("rst_mid",     1, 0, 1, 1, 0, 64'h56, 64'h78, 1,   0, 0, 0, 64'h0,  64'h0,  1, 0, 0));
    vecs.push_back(mk("rst_after",   0, 0, 0, 0, 0, 64'h0,  64'h0,  0,   1, 0, 0, 64'h0,  64'h0,  0, 0, 0));

    // Directed vector table.
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].vin, vecs[i].vi1, vecs[i].st,
            vecs[i].di0, vecs[i].di1, vecs[i].ordy);
      #1;
      check({vecs[i].name, "_in_ready"}, DW'(in_ready), DW'(vecs[i].e_rdy));
      cyc();
      check({vecs[i].name, "_valid_0"}, DW'(v0), DW'(vecs[i].e_v0));
      check({vecs[i].name, "_valid_1"}, DW'(v1), DW'(vecs[i].e_v1));
      if (vecs[i].e_v0 || vecs[i].chk_d) check({vecs[i].name, "_data_0"}, d0, vecs[i].e_d0);
      if (vecs[i].e_v1 || vecs[i].chk_d) check({vecs[i].name, "_data_1"}, d1, vecs[i].e_d1);
      check({vecs[i].name, "_split_cnt"}, DW'(cnt), DW'(vecs[i].e_cnt));
      check({vecs[i].name, "_sat_cnt"}, DW'(s_cnt), DW'(vecs[i].e_sat));
    end

    // Five back-to-back splits: 16-bit counter reaches 5, 2-bit one sticks at 3.
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 1, 1, DW'(64'h100 + 2 * k), DW'(64'h101 + 2 * k), 1);
      cyc();
      check("sat_older", d0, DW'(64'h100 + 2 * k));
      drive(0, 0, 0, 0, 0, '0, '0, 1);
      cyc();
      check("sat_younger", d0, DW'(64'h101 + 2 * k));
    end
    check("sat_cnt16", DW'(cnt), DW'(5));
    check("sat_cnt2", DW'(s_cnt), DW'(3));

    // Flush in the very cycle the parked instruction would reload.
    drive(0, 0, 0, 0, 0, '0, '0, 1);
    cyc();
    drive(0, 0, 1, 1, 1, 64'hA1, 64'hA2, 1);
    cyc();
    check("flr_lane0", d0, 64'hA1);
    drive(0, 1, 0, 0, 0, '0, '0, 1);
    #1;
    check("flr_ready", DW'(in_ready), DW'(0));
    cyc();
    check("flr_v0", DW'(v0), DW'(0));
    check("flr_v1", DW'(v1), DW'(0));
    drive(0, 0, 0, 0, 0, '0, '0, 1);
    cyc();
    check("flr_never_issued", DW'(v0), DW'(0));
    check("flr_cnt", DW'(cnt), DW'(6));

    // Reset mid-SECOND, then ready returns once reset drops.
    drive(0, 0, 1, 1, 1, 64'hC1, 64'hC2, 1);
    cyc();
    drive(1, 0, 0, 0, 0, '0, '0, 1);
    #1;
    check("rst2_ready", DW'(in_ready), DW'(0));
    cyc();
    check("rst2_v0", DW'(v0), DW'(0));
    check("rst2_cnt", DW'(cnt), DW'(0));
    check("rst2_sat", DW'(s_cnt), DW'(0));
    drive(0, 0, 0, 0, 0, '0, '0, 0);
    #1;
    check("rst2_ready_after", DW'(in_ready), DW'(1));
    cyc();
    check("rst2_v0_after", DW'(v0), DW'(0));

    // Randomized phase against the reference model (starts from reset state).
    m_v0 = 1'b0; m_v1 = 1'b0; m_d0 = '0; m_d1 = '0; m_wait.delete(); m_splits = 0;
    for (int n = 0; n < 2000; n++) begin
      logic          r_rst, r_fl, r_vin, r_v1, r_st, r_ordy;
      logic [DW-1:0] r_d0, r_d1;
      logic          free, e_rdy;
      r_rst  = ($urandom_range(0, 49) == 0);
      r_fl   = ($urandom_range(0, 11) == 0);
      r_vin  = ($urandom_range(0, 3) != 0);
      r_v1   = $urandom_range(0, 1) == 1;
      r_st   = $urandom_range(0, 1) == 1;
      r_ordy = ($urandom_range(0, 2) != 0);
      r_d0   = {$urandom, $urandom};
      r_d1   = {$urandom, $urandom};
      drive(r_rst, r_fl, r_vin, r_v1, r_st, r_d0, r_d1, r_ordy);

      free  = !(m_v0 || m_v1) || r_ordy;
      e_rdy = !r_rst && !r_fl && (m_wait.size() == 0) && free;
      #1;
      check("rnd_in_ready", DW'(in_ready), DW'(e_rdy));
      cyc();

      if (r_rst) begin
        m_v0 = 1'b0; m_v1 = 1'b0; m_wait.delete(); m_splits = 0;
      end else if (r_fl) begin
        m_v0 = 1'b0; m_v1 = 1'b0; m_wait.delete();
      end else if (m_wait.size() != 0) begin
        if (free) begin
          m_d0 = m_wait.pop_front();
          m_v0 = 1'b1;
          m_v1 = 1'b0;
        end
      end else if (e_rdy && r_vin) begin
        m_v0 = 1'b1;
        m_d0 = r_d0;
        if (r_v1 && r_st) begin
          m_wait.push_back(r_d1);
          m_v1 = 1'b0;
          m_splits++;
        end else begin
          m_v1 = r_v1;
          if (r_v1) m_d1 = r_d1;
        end
      end else if (r_ordy) begin
        m_v0 = 1'b0;
        m_v1 = 1'b0;
      end

      check("rnd_valid_0", DW'(v0), DW'(m_v0));
      check("rnd_valid_1", DW'(v1), DW'(m_v1));
      if (m_v0) check("rnd_data_0", d0, m_d0);
      if (m_v1) check("rnd_data_1", d1, m_d1);
      check("rnd_split_cnt", DW'(cnt), DW'((m_splits > 65535) ? 65535 : m_splits));
      check("rnd_sat_cnt", DW'(s_cnt), DW'((m_splits > 3) ? 3 : m_splits));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dual_issue_splitter
